// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and legality helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size is carried in funct3[1:0]; funct3[2] selects zero-extension for loads.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_NONE = 2'b11
    } size_t;

    function automatic size_t size_of(input logic [2:0] funct3);
        return size_t'(funct3[1:0]);
    endfunction

    // Stores only allow sb/sh/sw; loads reject the three unused encodings.
    function automatic logic illegal_funct3(input logic write, input logic [2:0] funct3);
        if (write) begin
            return !(funct3 inside {F3_B, F3_H, F3_W});
        end
        return funct3 inside {3'b011, 3'b110, 3'b111};
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the LSU (master) and the data-memory responder (slave).
interface data_mem_responder_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_funct3_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_funct3_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/replicated data, load extraction/extension, misalignment.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Decode size into lane enables, replicated store data and extended load data.
    always_comb begin
        be          = '0;
        wdata_lanes = '0;
        rdata       = '0;
        misaligned  = 1'b0;
        case (size_of(funct3))
            SZ_BYTE: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata       = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                misaligned  = addr_lo[0];
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata       = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                misaligned  = addr_lo != 2'b00;
                be          = '1;
                wdata_lanes = wdata;
                rdata       = rword;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, programmable wait states, owns a word RAM.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic [3:0]  next_cnt;

    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;

    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   st_data;
    logic [31:0]   ld_data;
    logic          misaligned;
    logic          out_of_range;
    logic          err;
    logic          accept;
    logic          commit;

    assign idx          = addr_q[AW+1:2];
    assign rword        = mem[idx];
    assign out_of_range = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
    assign err          = illegal_funct3(write_q, funct3_q) | misaligned | out_of_range;
    assign accept       = bus.req_valid_i & bus.req_ready_o;
    assign commit       = (state == WAIT) && (cnt == '0);

    assign bus.req_ready_o = (state == IDLE) && !reset_i;
    assign bus.rsp_valid_o = (state == RESP);
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_error_o = rsp_error_q;

    dmem_lane_align u_align (
        .addr_lo     (addr_q[1:0]),
        .funct3      (funct3_q),
        .wdata       (wdata_q),
        .rword       (rword),
        .be          (be),
        .wdata_lanes (st_data),
        .rdata       (ld_data),
        .misaligned  (misaligned)
    );

    // State and wait-counter registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic. Every request passes through WAIT with the counter loaded to
    // WAIT_CYCLES and leaves on zero, so response valid follows accept by WAIT_CYCLES+1 edges.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = WAIT;
                    next_cnt   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the request fields on accept; they stay put until the next accept.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
        end else if (accept) begin
            write_q  <= bus.req_write_i;
            addr_q   <= bus.req_addr_i;
            wdata_q  <= bus.req_wdata_i;
            funct3_q <= bus.req_funct3_i;
        end
    end

    // Response data/error are loaded on entry to RESP and held until the handshake.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else if (commit) begin
            rsp_error_q <= err;
            rsp_rdata_q <= (err || write_q) ? '0 : ld_data;
        end else if ((state == RESP) && bus.rsp_ready_i) begin
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end
    end

    // Byte-enabled store commit on the edge entering RESP; contents are never reset.
    always_ff @(posedge clock_i) begin
        if (commit && write_q && !err && !reset_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver pushes model expectations, monitor checks.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    typedef struct {
        logic [31:0] rd;
        bit          er;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t        q[$];
    logic [7:0]  mb [DEPTH*4];
    bit          force_low = 1'b0;

    bit          seen = 1'b0;
    int          rise = 0;
    logic [31:0] hold_rd;
    logic        hold_er;

    data_mem_responder_if bus();

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: byte-addressed memory, RISC-V load/store semantics.
    function automatic void model(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] f3, output logic [31:0] rd, output bit er);
        int     size;
        bit     uns;
        bit     ill;
        longint v;
        size = 4;
        uns  = 0;
        ill  = 0;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1; ill = wr; end
            3'd5: begin size = 2; uns = 1; ill = wr; end
            default: ill = 1;
        endcase
        er = ill || ((a % size) != 0) || ((a / 4) >= DEPTH);
        rd = '0;
        if (er) return;
        if (wr) begin
            for (int k = 0; k < size; k++) mb[a + k] = d[8*k +: 8];
            return;
        end
        v = 0;
        for (int k = size - 1; k >= 0; k--) v = v * 256 + longint'(mb[a + k]);
        if (!uns && v >= (longint'(1) << (8*size - 1))) v = v - (longint'(1) << (8*size));
        rd = v[31:0];
    endfunction

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3, input bit track);
        int          waited;
        logic [31:0] rd;
        bit          er;
        waited = 0;
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = wr;
        bus.req_addr_i   = a;
        bus.req_wdata_i  = d;
        bus.req_funct3_i = f3;
        while (!bus.req_ready_o) begin
            @(negedge clk);
            waited++;
            if (waited > 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: actual not accepted, required accept within 300 cycles");
                bus.req_valid_i = 1'b0;
                return;
            end
        end
        if (track) begin
            model(wr, a, d, f3, rd, er);
            q.push_back('{rd: rd, er: er, acc: cyc + 1});
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((q.size() != 0 || bus.rsp_valid_o) && w < 500) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 500) begin
            errors++;
            $display("FAIL drain_timeout: actual %0d responses pending, required 0", q.size());
        end
    endtask

    // Monitor: drives rsp_ready, checks stability in RESP and pops the scoreboard on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bus.rsp_ready_i = 1'b0;
            seen = 1'b0;
        end else begin
            bus.rsp_ready_i = force_low ? 1'b0 : ($urandom_range(3) != 0);
            if (bus.rsp_valid_o) begin
                chk("req_ready_in_resp", 32'(bus.req_ready_o), 32'd0);
                if (!seen) begin
                    seen    = 1'b1;
                    rise    = cyc;
                    hold_rd = bus.rsp_rdata_o;
                    hold_er = bus.rsp_error_o;
                end else begin
                    chk("rdata_stable", bus.rsp_rdata_o, hold_rd);
                    chk("error_stable", 32'(bus.rsp_error_o), 32'(hold_er));
                end
                if (bus.rsp_ready_i) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_rsp: actual response, required none");
                    end else begin
                        e = q.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata_o, e.rd);
                        chk("rsp_error", 32'(bus.rsp_error_o), 32'(e.er));
                        chk("latency", 32'(rise - e.acc), 32'(W + 1));
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          pick;

        bus.req_valid_i  = 1'b0;
        bus.req_write_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.req_funct3_i = '0;
        bus.rsp_ready_i  = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        chk("reset_rsp_error", 32'(bus.rsp_error_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 32'(bus.req_ready_o), 32'd1);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(i * 4), $urandom, F3_W, 1'b1);

        // Word store/load.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, F3_W, 1'b1);
        // Byte store, signed/unsigned byte loads, neighbouring lanes untouched.
        do_req(1'b1, 32'h15, 32'h123456AB, F3_B, 1'b1);
        do_req(1'b0, 32'h15, 32'h0, F3_B, 1'b1);
        do_req(1'b0, 32'h15, 32'h0, F3_BU, 1'b1);
        do_req(1'b0, 32'h14, 32'h0, F3_W, 1'b1);
        // Half store/loads, misaligned word accesses.
        do_req(1'b1, 32'h22, 32'hFFFF8001, F3_H, 1'b1);
        do_req(1'b0, 32'h22, 32'h0, F3_H, 1'b1);
        do_req(1'b0, 32'h22, 32'h0, F3_HU, 1'b1);
        do_req(1'b0, 32'h22, 32'h0, F3_W, 1'b1);
        do_req(1'b1, 32'h23, 32'hCAFEF00D, F3_W, 1'b1);
        do_req(1'b0, 32'h20, 32'h0, F3_W, 1'b1);
        do_req(1'b0, 32'h21, 32'h0, F3_H, 1'b1);
        // Range and funct3 errors, last legal byte.
        do_req(1'b0, 32'h400, 32'h0, F3_W, 1'b1);
        do_req(1'b1, 32'h400, 32'h11111111, F3_W, 1'b1);
        do_req(1'b0, 32'h0, 32'h0, 3'b011, 1'b1);
        do_req(1'b1, 32'h0, 32'h22222222, F3_BU, 1'b1);
        do_req(1'b0, 32'h0, 32'h0, F3_W, 1'b1);
        do_req(1'b1, 32'h3FF, 32'h0000005A, F3_B, 1'b1);
        do_req(1'b0, 32'h3FF, 32'h0, F3_BU, 1'b1);

        // Response held off for several cycles while another request waits.
        wait_idle();
        force_low = 1'b1;
        do_req(1'b0, 32'h10, 32'h0, F3_W, 1'b1);
        fork
            begin
                int w;
                w = 0;
                while (!bus.rsp_valid_o && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                repeat (4) @(negedge clk);
                force_low = 1'b0;
            end
        join_none
        do_req(1'b0, 32'h14, 32'h0, F3_W, 1'b1);

        // Reset during WAIT drops an uncommitted store.
        wait_idle();
        do_req(1'b1, 32'h30, 32'h12345678, F3_W, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("midreset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("midreset_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        chk("midreset_rsp_error", 32'(bus.rsp_error_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postreset_req_ready", 32'(bus.req_ready_o), 32'd1);
        do_req(1'b0, 32'h30, 32'h0, F3_W, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            wr   = 1'($urandom_range(1));
            pick = $urandom_range(9);
            if (pick == 0) begin
                f3 = 3'($urandom_range(7));
            end else if (wr) begin
                f3 = 3'($urandom_range(2));
            end else begin
                case ($urandom_range(4))
                    0: f3 = F3_B;
                    1: f3 = F3_H;
                    2: f3 = F3_W;
                    3: f3 = F3_BU;
                    default: f3 = F3_HU;
                endcase
            end
            if ($urandom_range(15) == 0) a = $urandom;
            else a = 32'($urandom_range(DEPTH * 4 - 1));
            if ($urandom_range(3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            do_req(wr, a, $urandom, f3, 1'b1);
        end

        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
